hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum consecutive data-memory wait cycles before a timeout (range 1..255).
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_read_ex  input  1  instruction in EX is a load.
REQ-005 rt_ex  input  5  load destination register in EX.
REQ-006 rs_id, rt_id  input  5 each  source registers of the instruction in ID.
REQ-007 uses_rt_id  input  1  ID instruction reads rt as a source (not as a destination).
REQ-008 branch_taken_ex  input  1  branch or jump in EX resolved as taken.
REQ-009 mem_req_mem  input  1  MEM-stage instruction issues a data-memory access.
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_write, if_id_write, id_ex_write, ex_mem_write  output  1 each  pipeline-register enables.
REQ-012 if_id_flush, id_ex_flush  output  1 each  insert a bubble into the register.
REQ-013 mem_timeout  output  1  sticky error flag.
REQ-014 stall_cycles  output  32  performance count of stall cycles.
REQ-015 flush_events  output  16  performance count of flush events.

Function
REQ-016 The FSM has three states: RUN, LOADUSE, MEMWAIT; outputs are combinational from the state and inputs, and state and counters are registered.
REQ-017 Load-use hazard (lu) = mem_read_ex && rt_ex!=0 && (rt_ex==rs_id || (uses_rt_id && rt_ex==rt_id)).
REQ-018 Memory wait (mw) = mem_req_mem && !mem_ready.
REQ-019 Condition priority: mw > branch_taken_ex > lu.
REQ-020 RUN with no condition: all write enables are 1 and both flushes are 0.
REQ-021 RUN with mw: all four write enables are 0, the flushes are 0, and the next state is MEMWAIT.
REQ-022 MEMWAIT: all write enables stay 0 while mw holds; the cycle mem_ready=1, the enables are 1 and the next state is RUN.
REQ-023 RUN with branch_taken_ex and no mw: pc_write=1, if_id_flush=1, id_ex_flush=1, flush_events+1, and the state stays RUN; a coincident lu is ignored because the instruction is wrong-path.
REQ-024 RUN with lu only: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, and the next state is LOADUSE.
REQ-025 LOADUSE lasts exactly 1 cycle: it behaves like RUN except that lu is masked, then returns to RUN; mw or branch in LOADUSE follows REQ-021/REQ-023.
REQ-026 The wait counter (8 bit) clears on entry to MEMWAIT and increments each MEMWAIT cycle; when it reaches MAX_WAIT, mem_timeout is set (sticky until rst) and the FSM stays frozen.
REQ-027 Register 0 never causes a load-use stall.
REQ-028 stall_cycles increments in every cycle where pc_write=0; both counters saturate at all-ones.

Reset
REQ-029 On rst=1 at a clock edge: state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0, flush_events=0.
REQ-030 During the rst cycle, outputs decode as RUN with all inputs ignored: enables 1 and flushes 0.
REQ-031 rst asserted in MEMWAIT or LOADUSE abandons the stall with no residual bubble.

Configuration
REQ-032 Macro HAZARD_PERF_EN: when defined, stall_cycles and flush_events count per REQ-028/REQ-023.
REQ-033 When HAZARD_PERF_EN is undefined, both counters are absent and the outputs are tied to 0; all other behaviour is identical.

Verification
REQ-034 mem_read_ex=1, rt_ex=5, rs_id=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 in that cycle; the next cycle is LOADUSE with all enables 1; stall_cycles=1.
REQ-035 rt_ex=0, rs_id=0, mem_read_ex=1 -> no stall; also rt_ex=7, rt_id=7, uses_rt_id=0 -> no stall.
REQ-036 branch_taken_ex=1 together with the lu of REQ-034 -> if_id_flush=1, id_ex_flush=1, pc_write=1, no LOADUSE entry, flush_events=1.
REQ-037 mem_req_mem=1, mem_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, enables 1 on the 4th cycle, mem_timeout=0, stall_cycles=3.
REQ-038 MAX_WAIT=4, mem_ready held 0 for 6 cycles, then rst -> mem_timeout=1 after the 4th wait cycle and stays 1; after rst, mem_timeout=0 and state=RUN.
REQ-039 Build without HAZARD_PERF_EN and rerun REQ-034 -> identical control outputs, stall_cycles=0.

Source files
------------

// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if -- signal bundle between the pipeline datapath and hazard_unit.
//
// Pipeline side (master) drives the hazard conditions:
//   mem_read_ex, rt_ex      load in EX and its destination register
//   rs_id, rt_id            source registers of the ID instruction
//   uses_rt_id              ID instruction reads rt as a source
//   branch_taken_ex         branch/jump in EX resolved as taken
//   mem_req_mem, mem_ready  MEM-stage data-memory request / completion
// Hazard unit (slave) drives the pipeline controls:
//   pc_write, if_id_write, id_ex_write, ex_mem_write   register enables
//   if_id_flush, id_ex_flush                          bubble inserts
//   mem_timeout                                       sticky error flag
//   stall_cycles, flush_events                        performance counters
// ---------------------------------------------------------------------------
interface hazard_if;
  logic        mem_read_ex;
  logic [4:0]  rt_ex;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        uses_rt_id;
  logic        branch_taken_ex;
  logic        mem_req_mem;
  logic        mem_ready;

  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;

  modport master (
    output mem_read_ex, rt_ex, rs_id, rt_id, uses_rt_id,
           branch_taken_ex, mem_req_mem, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  mem_read_ex, rt_ex, rs_id, rt_id, uses_rt_id,
           branch_taken_ex, mem_req_mem, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit -- pipeline stall/flush controller.
//
// Resolves three conditions with priority memory-wait > taken branch >
// load-use, drives the pipeline-register enables and bubble inserts, and
// flags a data-memory access that waits MAX_WAIT cycles in MEMWAIT.
//
// Ports:
//   clk  pipeline clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   hz   hazard_if.slave bundle (conditions in, controls/counters out)
// Parameter:
//   MAX_WAIT  MEMWAIT cycles before mem_timeout is raised (1..255)
// Build option:
//   HAZARD_PERF_EN  when defined, stall_cycles / flush_events count;
//                   otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic      clk,
  input logic      rst,
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {RUN, LOADUSE, MEMWAIT} state_t;

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;

  logic lu, mw;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush;
  logic flush_evt;

  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign lu = hz.mem_read_ex && (hz.rt_ex != 5'd0) &&
              ((hz.rt_ex == hz.rs_id) || (hz.uses_rt_id && (hz.rt_ex == hz.rt_id)));
  assign mw = hz.mem_req_mem && !hz.mem_ready;

  // Next-state and control decode. While rst is high the defaults (plain RUN
  // with every condition ignored) are what reach the outputs. LOADUSE only
  // differs from RUN in that lu is masked, which keeps the stall to one cycle.
  // Once the timeout flag is set the pipeline stays frozen until reset.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    flush_evt    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN, LOADUSE: begin
          if (mw) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            wait_d       = 8'd0;
            state_d      = MEMWAIT;
          end else if (hz.branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
            state_d     = RUN;
          end else if (lu && (state_q == RUN)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = LOADUSE;
          end else begin
            state_d = RUN;
          end
        end
        MEMWAIT: begin
          if (timeout_q || mw) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if (!timeout_q) begin
              wait_d = wait_q + 8'd1;
              if ((wait_q + 8'd1) == MaxWaitC) begin
                timeout_d = 1'b1;
              end
            end
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_write  = id_ex_write;
  assign hz.ex_mem_write = ex_mem_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.mem_timeout  = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  // Saturating performance counters: a stall cycle is any cycle the PC is
  // held, a flush event is any taken-branch squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush_evt && (flush_q != '1)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
`else
  logic perf_unused;
  assign perf_unused     = flush_evt;
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_events = 16'd0;
`endif

endmodule
